// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: fetches 8-bit instructions over req/ack, strobes them
// into the IR, waits for execution, then advances/redirects the PC or halts.
module fetch_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             start,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [7:0]       imem_rdata,
  output logic             ir_load,
  output logic [7:0]       ir_data,
  input  logic             exec_busy,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             halt_op,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_HALT
  } state_t;

  state_t           state_reg, state_next;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic [CNT_W-1:0] retired_reg, retired_next;
  logic [7:0]       ir_data_reg, ir_data_next;

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg   <= S_IDLE;
      pc_reg      <= RESET_PC;
      retired_reg <= '0;
      ir_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      retired_reg <= retired_next;
      ir_data_reg <= ir_data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    retired_next = retired_reg;
    ir_data_next = ir_data_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_data_next = imem_rdata;
          state_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        state_next = S_EXEC;
      end
      S_EXEC: begin
        // halt wins over branch; both are only looked at on the exit cycle
        if (!exec_busy) begin
          retired_next = retired_reg + CNT_W'(1);
          if (halt_op) begin
            state_next = S_HALT;
          end else begin
            state_next = S_FETCH;
            pc_next    = branch_taken ? branch_target : pc_reg + PC_W'(1);
          end
        end
      end
      S_HALT: begin
        if (start) begin
          pc_next      = RESET_PC;
          retired_next = '0;
          state_next   = S_FETCH;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign imem_req  = (state_reg == S_FETCH);
  assign imem_addr = pc_reg;
  assign ir_load   = (state_reg == S_LOAD);
  assign ir_data   = ir_data_reg;
  assign pc        = pc_reg;
  assign running   = (state_reg == S_FETCH) || (state_reg == S_LOAD) || (state_reg == S_EXEC);
  assign done      = (state_reg == S_HALT);
  assign retired   = retired_reg;

endmodule
